game_ctrl_mc: RTL and testbench
===============================

Name: game_ctrl_mc

Overview:
Multi-channel successor to the single-enemy game controller. It takes per-pixel alpha overlap from the player sprite, the bullet layer and N independent enemy channels, and accumulates collisions across a video frame. At each frame boundary it resolves those collisions into lives, score and per-channel event pulses. It also runs the game status FSM (PRERUN/RUN/PAUSE/OVER) that the sprite, enemy and display blocks consume. It sits between the sprite renderers and the game logic / HUD in the clk_vga domain.

Parameters:
N_ENEMY, 4, number of enemy sprite channels (1..16)
LIVES, 3, lives loaded at game start (1..15)
LIVES_W, 4, width of lives counter
SCORE_W, 16, score counter width; saturates at all-ones
INVUL_FRAMES, 60, frames of invulnerability after a player hit
INVUL_W, 8, width of invulnerability counter (must hold INVUL_FRAMES)

Ports:
clk_vga  in  1  pixel clock; sole clock
rst  in  1  synchronous, active-high reset
frame_end_i  in  1  one-cycle pulse after the last visible pixel of a frame
me_alpha_i  in  1  player sprite opaque at current pixel
bullet_alpha_i  in  1  any bullet opaque at current pixel
enemy_alpha_i  in  N_ENEMY  enemy[k] opaque at current pixel
gamestart_i  in  1  start/restart request pulse
pause_i  in  1  pause toggle pulse
game_status_o  out  GAME_STATUS_BIT_LEN  current FSM state
lives_o  out  LIVES_W  remaining lives
score_o  out  SCORE_W  enemies destroyed
invul_o  out  1  invulnerability window active
crash_me_enemy_o  out  N_ENEMY  per-channel one-cycle pulse: enemy[k] touched player this frame
crash_enemy_bullet_o  out  N_ENEMY  per-channel one-cycle pulse: enemy[k] destroyed this frame
bomb_o  out  1  one-cycle pulse: any enemy destroyed this frame (explosion trigger)

Behaviour:
- Reset (sync, rst=1 at clk_vga edge): status=PRERUN, lives=LIVES, score=0, invul counter=0, all sticky flags=0, all pulse outputs=0. Reset overrides every other input in the same cycle.
- Pixel accumulation, only while status=RUN:
  - hit_be[k] |= bullet_alpha_i & enemy_alpha_i[k]
  - hit_me[k] |= me_alpha_i & enemy_alpha_i[k]
  - Flags are sticky until frame resolution.
  - In PRERUN, PAUSE and OVER, flags are held at 0.
- Frame resolution on the frame_end_i cycle. All results become visible the next cycle: latency 1. Pulses last exactly 1 cycle.
  - crash_enemy_bullet_o = hit_be. bomb_o = |hit_be.
  - score += popcount(hit_be), saturating at 2^SCORE_W-1.
  - crash_me_enemy_o = hit_me, pulsed regardless of invulnerability.
  - If |hit_me and invul counter==0: lives -= 1 (once per frame, however many channels hit) and invul counter = INVUL_FRAMES.
  - Else if invul counter>0: it decrements by 1.
  - A channel hit by both bullet and player in the same frame scores the kill and also costs a life.
  - Flags clear on the frame_end_i cycle. A pixel hit on that same cycle is dropped.
- invul_o = (invul counter != 0).
- FSM (encodings from the shared package: PAUSE=000, RUN=001, PRERUN=010, OVER=011):
  - PRERUN --gamestart_i--> RUN
  - RUN --pause_i--> PAUSE; PAUSE --pause_i--> RUN
  - RUN --life decrement reaching 0 at frame resolution--> OVER. lives_o shows 0.
  - OVER --gamestart_i--> RUN. On that edge: lives=LIVES, score=0, invul counter=0, flags cleared.
  - gamestart_i in RUN or PAUSE is ignored. pause_i in PRERUN or OVER is ignored.
  - Same cycle in RUN: frame resolution causing OVER beats pause_i, so OVER is entered.
  - Same cycle: gamestart_i and pause_i in PRERUN → RUN; the pause is ignored.
- Frame resolution with status≠RUN: no score/lives change. The invul counter is frozen in PAUSE.
- Outputs are all registered. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package/define header: GAME_STATUS_BIT_LEN and the four STATUS_* encodings, moved out of local params so the sprite and HUD blocks share them.
- One natural sub-module, collision_accum: the per-channel sticky flag pair with clear-on-frame_end. It is instantiated N_ENEMY times via generate.
- The FSM, lives/score/invul counters and popcount stay in the top.

Test Plan:
- Reset then gamestart_i → status 010→001 next cycle; lives_o=3, score_o=0, all pulses 0.
- RUN: bullet+enemy[2] overlap for 5 pixels, then frame_end_i → next cycle crash_enemy_bullet_o=4'b0100 for 1 cycle, bomb_o=1, score_o=1. Repeat with enemies 0,1,3 in the same frame → score_o=4.
- RUN: me+enemy[0] and me+enemy[3] in one frame → crash_me_enemy_o=4'b1001, lives_o=2, invul_o=1. A hit on the next frame does not decrement. After 60 frames invul_o=0, and the next hit gives lives_o=1.
- Third effective hit → lives_o=0 and status=011. pause_i asserted the same cycle as frame_end_i → still 011. gamestart_i → 001, lives_o=3, score_o=0.
- pause_i in RUN → 000. Overlaps plus frame_end_i → no pulses and no score change. pause_i → 001.
- Score preloaded to 16'hFFFE, then 3 kills in one frame → score_o=16'hFFFF. Assert rst mid-frame with flags set → next frame_end_i produces no pulses and status=010.

Source files
------------

// File: rtl/game_ctrl_mc_pkg.sv
// Shared game status definitions for the sprite, enemy, HUD and game control blocks.
//   GAME_STATUS_BIT_LEN : width of the game status bus
//   game_status_e       : PAUSE=000, RUN=001, PRERUN=010, OVER=011
//   popcount16          : number of set bits in a 16-bit vector
package game_ctrl_mc_pkg;

   localparam int GAME_STATUS_BIT_LEN = 3;

   typedef enum logic [GAME_STATUS_BIT_LEN-1:0] {
      STATUS_PAUSE  = 3'b000,
      STATUS_RUN    = 3'b001,
      STATUS_PRERUN = 3'b010,
      STATUS_OVER   = 3'b011
   } game_status_e;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) c = c + {4'b0000, v[i]};
      return c;
   endfunction

endpackage

// File: rtl/game_ctrl_mc_collision_accum.sv
// Sticky collision flags for one enemy channel across a video frame.
//   clk_vga, rst      : pixel clock, synchronous active-high reset
//   clr               : drop both flags this cycle (frame boundary or not running)
//   acc_en            : accumulate pixel overlaps this cycle
//   me_alpha          : player sprite opaque at current pixel
//   bullet_alpha      : any bullet opaque at current pixel
//   enemy_alpha       : this enemy opaque at current pixel
//   hit_be / hit_me   : bullet-enemy / player-enemy overlap seen this frame
module game_ctrl_mc_collision_accum (
   input  logic clk_vga,
   input  logic rst,
   input  logic clr,
   input  logic acc_en,
   input  logic me_alpha,
   input  logic bullet_alpha,
   input  logic enemy_alpha,
   output logic hit_be,
   output logic hit_me
);

   // Clear wins over accumulate, so a pixel overlap on the frame_end cycle is dropped.
   always_ff @(posedge clk_vga) begin
      if (rst || clr) begin
         hit_be <= 1'b0;
         hit_me <= 1'b0;
      end else if (acc_en) begin
         hit_be <= hit_be | (bullet_alpha & enemy_alpha);
         hit_me <= hit_me | (me_alpha & enemy_alpha);
      end
   end

endmodule

// File: rtl/game_ctrl_mc.sv
// Multi-channel game controller: accumulates per-frame collisions between the
// player, bullets and N_ENEMY enemy channels, resolves them at frame_end_i into
// lives, score and per-channel event pulses, and runs the game status FSM.
//   clk_vga, rst            : pixel clock, synchronous active-high reset
//   frame_end_i             : one-cycle pulse after the last visible pixel
//   me_alpha_i              : player sprite opaque at current pixel
//   bullet_alpha_i          : any bullet opaque at current pixel
//   enemy_alpha_i[k]        : enemy k opaque at current pixel
//   gamestart_i, pause_i    : start/restart and pause-toggle pulses
//   game_status_o           : current game state
//   lives_o, score_o        : remaining lives, enemies destroyed (saturating)
//   invul_o                 : invulnerability window active
//   crash_me_enemy_o[k]     : pulse, enemy k touched the player last frame
//   crash_enemy_bullet_o[k] : pulse, enemy k destroyed last frame
//   bomb_o                  : pulse, any enemy destroyed last frame
module game_ctrl_mc
   import game_ctrl_mc_pkg::*;
#(
   parameter int N_ENEMY      = 4,
   parameter int LIVES        = 3,
   parameter int LIVES_W      = 4,
   parameter int SCORE_W      = 16,
   parameter int INVUL_FRAMES = 60,
   parameter int INVUL_W      = 8
) (
   input  logic                           clk_vga,
   input  logic                           rst,
   input  logic                           frame_end_i,
   input  logic                           me_alpha_i,
   input  logic                           bullet_alpha_i,
   input  logic [N_ENEMY-1:0]             enemy_alpha_i,
   input  logic                           gamestart_i,
   input  logic                           pause_i,
   output logic [GAME_STATUS_BIT_LEN-1:0] game_status_o,
   output logic [LIVES_W-1:0]             lives_o,
   output logic [SCORE_W-1:0]             score_o,
   output logic                           invul_o,
   output logic [N_ENEMY-1:0]             crash_me_enemy_o,
   output logic [N_ENEMY-1:0]             crash_enemy_bullet_o,
   output logic                           bomb_o
);

   // Sum is wide enough for score plus a full 16-channel kill count.
   localparam int SUM_W = ((SCORE_W > 5) ? SCORE_W : 5) + 1;
   localparam logic [SUM_W-1:0] SCORE_SAT = SUM_W'((64'd1 << SCORE_W) - 64'd1);

   game_status_e         status_q;
   logic [LIVES_W-1:0]   lives_q;
   logic [SCORE_W-1:0]   score_q;
   logic [INVUL_W-1:0]   invul_q;
   logic [N_ENEMY-1:0]   crash_me_q;
   logic [N_ENEMY-1:0]   crash_be_q;
   logic                 bomb_q;

   logic [N_ENEMY-1:0]   hit_be;
   logic [N_ENEMY-1:0]   hit_me;
   logic                 acc_en;
   logic                 acc_clr;

   assign acc_en  = (status_q == STATUS_RUN);
   assign acc_clr = frame_end_i | ~acc_en;

   for (genvar k = 0; k < N_ENEMY; k++) begin : g_ch
      game_ctrl_mc_collision_accum u_acc (
         .clk_vga      (clk_vga),
         .rst          (rst),
         .clr          (acc_clr),
         .acc_en       (acc_en),
         .me_alpha     (me_alpha_i),
         .bullet_alpha (bullet_alpha_i),
         .enemy_alpha  (enemy_alpha_i[k]),
         .hit_be       (hit_be[k]),
         .hit_me       (hit_me[k])
      );
   end

   logic [4:0]         kills;
   logic [SUM_W-1:0]   score_sum;
   logic [SCORE_W-1:0] score_next;
   logic               player_hit;
   logic               player_dies;

   assign kills      = popcount16(16'(hit_be));
   assign score_sum  = SUM_W'(score_q) + SUM_W'(kills);
   assign score_next = (score_sum > SCORE_SAT) ? SCORE_W'(SCORE_SAT) : score_sum[SCORE_W-1:0];

   // A player hit only counts outside the invulnerability window, once per frame.
   assign player_hit  = frame_end_i & (|hit_me) & (invul_q == '0);
   assign player_dies = player_hit & (lives_q == LIVES_W'(1));

   always_ff @(posedge clk_vga) begin
      if (rst) begin
         status_q   <= STATUS_PRERUN;
         lives_q    <= LIVES_W'(LIVES);
         score_q    <= '0;
         invul_q    <= '0;
         crash_me_q <= '0;
         crash_be_q <= '0;
         bomb_q     <= 1'b0;
      end else begin
         crash_me_q <= '0;
         crash_be_q <= '0;
         bomb_q     <= 1'b0;
         case (status_q)
            STATUS_PRERUN: begin
               if (gamestart_i) status_q <= STATUS_RUN;
            end
            STATUS_RUN: begin
               if (frame_end_i) begin
                  crash_be_q <= hit_be;
                  crash_me_q <= hit_me;
                  bomb_q     <= |hit_be;
                  score_q    <= score_next;
                  if (player_hit) begin
                     lives_q <= lives_q - LIVES_W'(1);
                     invul_q <= INVUL_W'(INVUL_FRAMES);
                  end else if (invul_q != '0) begin
                     invul_q <= invul_q - INVUL_W'(1);
                  end
               end
               // Losing the last life takes priority over a same-cycle pause.
               if (player_dies)  status_q <= STATUS_OVER;
               else if (pause_i) status_q <= STATUS_PAUSE;
            end
            STATUS_PAUSE: begin
               if (pause_i) status_q <= STATUS_RUN;
            end
            STATUS_OVER: begin
               if (gamestart_i) begin
                  status_q <= STATUS_RUN;
                  lives_q  <= LIVES_W'(LIVES);
                  score_q  <= '0;
                  invul_q  <= '0;
               end
            end
            default: status_q <= STATUS_PRERUN;
         endcase
      end
   end

   assign game_status_o        = status_q;
   assign lives_o              = lives_q;
   assign score_o              = score_q;
   assign invul_o              = (invul_q != '0);
   assign crash_me_enemy_o     = crash_me_q;
   assign crash_enemy_bullet_o = crash_be_q;
   assign bomb_o               = bomb_q;

endmodule

// File: tb/tb_game_ctrl_mc.sv
// Directed bench for game_ctrl_mc with a frame-level reference model.
// A second instance with a 3-bit score exercises saturation cheaply.
module tb_game_ctrl_mc;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic fe = 1'b0, me = 1'b0, bul = 1'b0, gs = 1'b0, pse = 1'b0;
   logic [3:0] en = 4'b0;

   logic [2:0]  status, s_status;
   logic [3:0]  lives, s_lives;
   logic [15:0] score;
   logic [2:0]  s_score;
   logic        invul, s_invul, bomb, s_bomb;
   logic [3:0]  cme, cbe, s_cme, s_cbe;

   int nchecks = 0;
   int nerr = 0;
   bit chk_en = 0;

   always #5 clk = ~clk;

   game_ctrl_mc u_dut (
      .clk_vga(clk), .rst(rst), .frame_end_i(fe), .me_alpha_i(me),
      .bullet_alpha_i(bul), .enemy_alpha_i(en), .gamestart_i(gs), .pause_i(pse),
      .game_status_o(status), .lives_o(lives), .score_o(score), .invul_o(invul),
      .crash_me_enemy_o(cme), .crash_enemy_bullet_o(cbe), .bomb_o(bomb)
   );

   game_ctrl_mc #(.SCORE_W(3)) u_dut_small (
      .clk_vga(clk), .rst(rst), .frame_end_i(fe), .me_alpha_i(me),
      .bullet_alpha_i(bul), .enemy_alpha_i(en), .gamestart_i(gs), .pause_i(pse),
      .game_status_o(s_status), .lives_o(s_lives), .score_o(s_score), .invul_o(s_invul),
      .crash_me_enemy_o(s_cme), .crash_enemy_bullet_o(s_cbe), .bomb_o(s_bomb)
   );

   // Reference model: status codes 0 PAUSE, 1 RUN, 2 PRERUN, 3 OVER.
   // Score is an unbounded kill count; each instance shows it clipped to its width.
   int m_st = 2, m_lives = 3, m_score = 0, m_invul = 0;
   bit [3:0] m_be = 0, m_me = 0, m_pbe = 0, m_pme = 0;

   always @(posedge clk) begin : model
      int st, lv, sc, iv;
      bit [3:0] be, mh, pbe, pme;
      bit run;
      st = m_st; lv = m_lives; sc = m_score; iv = m_invul;
      be = m_be; mh = m_me; pbe = 0; pme = 0;
      if (rst) begin
         st = 2; lv = 3; sc = 0; iv = 0; be = 0; mh = 0;
      end else begin
         run = (m_st == 1);
         if (fe) begin
            if (run) begin
               pbe = be; pme = mh;
               sc = sc + $countones(be);
               if (mh != 0 && iv == 0) begin lv = lv - 1; iv = 60; end
               else if (iv > 0) iv = iv - 1;
            end
            be = 0; mh = 0;
         end else if (run) begin
            if (bul) be = be | en;
            if (me)  mh = mh | en;
         end else begin
            be = 0; mh = 0;
         end
         case (m_st)
            2: if (gs) st = 1;
            1: if (lv == 0) st = 3; else if (pse) st = 0;
            0: if (pse) st = 1;
            3: if (gs) begin st = 1; lv = 3; sc = 0; iv = 0; end
            default: st = 2;
         endcase
      end
      m_st <= st; m_lives <= lv; m_score <= sc; m_invul <= iv;
      m_be <= be; m_me <= mh; m_pbe <= pbe; m_pme <= pme;
   end

   task automatic chk(input string name, input int act, input int exp);
      nchecks++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("status", int'(status), m_st);
         chk("lives", int'(lives), m_lives);
         chk("score", int'(score), (m_score > 65535) ? 65535 : m_score);
         chk("invul", int'(invul), int'(m_invul != 0));
         chk("crash_me", int'(cme), int'(m_pme));
         chk("crash_be", int'(cbe), int'(m_pbe));
         chk("bomb", int'(bomb), int'(m_pbe != 0));
         chk("small_status", int'(s_status), m_st);
         chk("small_score", int'(s_score), (m_score > 7) ? 7 : m_score);
         chk("small_bomb", int'(s_bomb), int'(m_pbe != 0));
      end
   end

   // Drive one cycle of inputs; returns 1 time unit after the edge that consumed them.
   task automatic step(input bit i_me, input bit i_bul, input bit [3:0] i_en,
                       input bit i_fe, input bit i_gs, input bit i_pse);
      me = i_me; bul = i_bul; en = i_en; fe = i_fe; gs = i_gs; pse = i_pse;
      @(posedge clk); #1;
      me = 0; bul = 0; en = 0; fe = 0; gs = 0; pse = 0;
   endtask

   task automatic frame_end();
      step(0, 0, 4'b0000, 1, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      @(posedge clk); #1;
      chk_en = 1;
      @(posedge clk); #1;
      rst = 0;
      chk("reset_status", int'(status), 2);
      chk("reset_lives", int'(lives), 3);
      chk("reset_score", int'(score), 0);

      step(0, 0, 4'b0000, 0, 0, 1);            // pause ignored in PRERUN
      chk("prerun_pause", int'(status), 2);
      step(0, 0, 4'b0000, 0, 1, 0);
      chk("start_run", int'(status), 1);

      repeat (5) step(0, 1, 4'b0100, 0, 0, 0);
      frame_end();
      chk("kill2_pulse", int'(cbe), 4);
      chk("kill2_bomb", int'(bomb), 1);
      chk("kill2_score", int'(score), 1);
      step(0, 0, 4'b0000, 0, 0, 0);
      chk("pulse_one_cycle", int'(cbe), 0);

      repeat (2) step(0, 1, 4'b1011, 0, 0, 0);
      frame_end();
      chk("kill3_score", int'(score), 4);

      step(1, 0, 4'b1001, 0, 0, 0);
      frame_end();
      chk("me_hit_pulse", int'(cme), 9);
      chk("me_hit_lives", int'(lives), 2);
      chk("me_hit_invul", int'(invul), 1);
      step(1, 0, 4'b0001, 0, 0, 0);
      frame_end();
      chk("invul_no_dec", int'(lives), 2);
      repeat (59) frame_end();
      chk("invul_expired", int'(invul), 0);
      step(1, 0, 4'b0010, 0, 0, 0);
      frame_end();
      chk("second_hit", int'(lives), 1);
      repeat (60) frame_end();

      step(1, 0, 4'b0001, 0, 0, 0);
      step(0, 0, 4'b0000, 1, 0, 1);            // death beats same-cycle pause
      chk("over_lives", int'(lives), 0);
      chk("over_status", int'(status), 3);
      step(0, 0, 4'b0000, 0, 0, 1);
      chk("over_pause", int'(status), 3);
      step(0, 0, 4'b0000, 0, 1, 0);
      chk("restart_status", int'(status), 1);
      chk("restart_lives", int'(lives), 3);
      chk("restart_score", int'(score), 0);

      step(0, 0, 4'b0000, 0, 0, 1);
      chk("paused", int'(status), 0);
      step(1, 1, 4'b1111, 0, 0, 0);
      frame_end();
      chk("paused_no_pulse", int'(cbe), 0);
      chk("paused_score", int'(score), 0);
      step(0, 0, 4'b0000, 0, 0, 1);
      chk("resumed", int'(status), 1);

      step(1, 1, 4'b0100, 0, 0, 0);
      frame_end();
      chk("both_score", int'(score), 1);
      chk("both_lives", int'(lives), 2);
      chk("both_cme", int'(cme), 4);

      step(0, 1, 4'b0001, 1, 0, 0);            // overlap on frame_end cycle is dropped
      chk("fe_drop", int'(cbe), 0);
      frame_end();
      chk("fe_drop_next", int'(cbe), 0);
      step(0, 0, 4'b0000, 0, 1, 0);
      chk("gs_in_run", int'(status), 1);

      step(0, 1, 4'b1111, 0, 0, 0);
      frame_end();
      step(0, 1, 4'b0001, 0, 0, 0);
      frame_end();
      chk("pre_sat_small", int'(s_score), 6);
      step(0, 1, 4'b0111, 0, 0, 0);
      frame_end();
      chk("sat_small", int'(s_score), 7);
      chk("sat_big", int'(score), 9);
      step(0, 1, 4'b1000, 0, 0, 0);
      frame_end();
      chk("sat_hold", int'(s_score), 7);

      step(1, 1, 4'b1111, 0, 0, 0);
      rst = 1;
      step(0, 0, 4'b0000, 0, 0, 0);
      rst = 0;
      frame_end();
      chk("rst_no_pulse", int'(cbe), 0);
      chk("rst_status", int'(status), 2);
      step(0, 0, 4'b0000, 0, 1, 1);
      chk("gs_pause_prerun", int'(status), 1);
      step(0, 0, 4'b0000, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule
